dac_switch_driver: RTL and testbench

- Digital front-end of the current-steering DAC. It sits directly upstream of the switching pairs that feed the differential resistor load.
- Registers each input code and splits it into a thermometer-coded MSB segment and a binary LSB segment.
- Optionally rotates the MSB unit-cell selection with data-weighted averaging (DWA) to spread cell mismatch.
- Drives complementary gate-control pairs (sw/sw_b) so that each cell steers its current to Iin or Iinb.

---
 rtl/dac_pkg.sv | 20 ++
 rtl/dwa_rotator.sv | 47 ++++
 rtl/dac_switch_driver.sv | 120 ++++++++++++
 tb/tb_dac_switch_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC switch driver: segment widths,
// unit-cell count and the bit-vector typedefs used across the pipeline.
package dac_pkg;

    // Thermometer (MSB) segment width and resulting number of unit cells.
    localparam int MSB_BITS = 4;
    localparam int N_CELLS  = (1 << MSB_BITS) - 1;

    // Binary-weighted (LSB) segment width.
    localparam int LSB_BITS = 6;

    // Full input code width; always derived from the two segments.
    localparam int DIN_W    = MSB_BITS + LSB_BITS;

    typedef logic [MSB_BITS-1:0] msb_code_t;
    typedef logic [LSB_BITS-1:0] lsb_code_t;
    typedef logic [N_CELLS-1:0]  cell_vec_t;
    typedef logic [DIN_W-1:0]    din_code_t;

endpackage : dac_pkg

// File: rtl/dwa_rotator.sv
// Combinational data-weighted-averaging selector. Given a cell count k and a
// start pointer, turns on k consecutive unit cells starting at the pointer,
// wrapping modulo N_CELLS, and returns the pointer for the next sample.
// Feeding ptr_i = 0 yields a plain thermometer code (cells 0..k-1).
module dwa_rotator #(
    parameter int N_CELLS = 15,
    parameter int PTR_W   = 4
) (
    input  logic [PTR_W-1:0]   k_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [N_CELLS-1:0] cells_o,
    output logic [PTR_W-1:0]   next_ptr_o
);

    // One extra bit so i + N_CELLS and ptr + k never overflow (both < 2*N).
    localparam int EW = PTR_W + 1;
    localparam logic [EW-1:0] N_EXT = EW'(N_CELLS);

    logic [EW-1:0] ptr_ext;
    logic [EW-1:0] k_ext;
    logic [EW-1:0] ptr_sum;

    assign ptr_ext = {1'b0, ptr_i};
    assign k_ext   = {1'b0, k_i};

    // Cell i is on when its distance from the pointer, measured forward
    // around the ring of N_CELLS cells, is smaller than k.
    generate
        for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
            localparam logic [EW-1:0] IDX      = EW'(gi);
            localparam logic [EW-1:0] IDX_WRAP = EW'(gi + N_CELLS);

            logic [EW-1:0] offset;

            assign offset      = (IDX >= ptr_ext) ? (IDX - ptr_ext)
                                                  : (IDX_WRAP - ptr_ext);
            assign cells_o[gi] = (offset < k_ext);
        end
    endgenerate

    // Advance the pointer by k; a single conditional subtract is enough
    // because ptr < N and k <= N.
    assign ptr_sum    = ptr_ext + k_ext;
    assign next_ptr_o = (ptr_sum >= N_EXT) ? PTR_W'(ptr_sum - N_EXT)
                                           : PTR_W'(ptr_sum);

endmodule : dwa_rotator

// File: rtl/dac_switch_driver.sv
// Digital front-end of the current-steering DAC. Stage 1 registers the input
// code (forcing zero when muted); stage 2 decodes it into thermometer unit-cell
// steers (optionally DWA-rotated) plus binary LSB steers, and registers both
// the true and complementary gate controls in the same flops so the switching
// pairs never see a skew introduced by post-register inversion.
module dac_switch_driver
    import dac_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [DIN_W-1:0]    din,
    input  logic                din_valid,
    input  logic                dem_en,
    input  logic                mute,
    output logic [N_CELLS-1:0]  sw_msb,
    output logic [N_CELLS-1:0]  sw_msb_b,
    output logic [LSB_BITS-1:0] sw_lsb,
    output logic [LSB_BITS-1:0] sw_lsb_b,
    output logic [MSB_BITS-1:0] dwa_ptr,
    output logic                out_valid
);

    // Stage 1 state.
    din_code_t code_q, code_d;
    logic      v1_q, v1_d;

    // Stage 2 state (output register and DWA pointer).
    cell_vec_t sw_msb_q,   sw_msb_d;
    cell_vec_t sw_msb_b_q, sw_msb_b_d;
    lsb_code_t sw_lsb_q,   sw_lsb_d;
    lsb_code_t sw_lsb_b_q, sw_lsb_b_d;
    msb_code_t dwa_ptr_q,  dwa_ptr_d;
    logic      out_valid_q, out_valid_d;

    // Decode path.
    msb_code_t k;
    msb_code_t rot_ptr;
    msb_code_t rot_next_ptr;
    cell_vec_t rot_cells;

    assign k = code_q[DIN_W-1:LSB_BITS];

    // With DWA off the rotator starts at cell 0, which is a plain thermometer.
    assign rot_ptr = dem_en ? dwa_ptr_q : '0;

    dwa_rotator #(
        .N_CELLS (N_CELLS),
        .PTR_W   (MSB_BITS)
    ) u_dwa_rotator (
        .k_i        (k),
        .ptr_i      (rot_ptr),
        .cells_o    (rot_cells),
        .next_ptr_o (rot_next_ptr)
    );

    // Stage 1 next state: capture a new sample, muted samples become code 0.
    always_comb begin
        v1_d   = din_valid;
        code_d = code_q;
        if (din_valid) begin
            code_d = mute ? '0 : din;
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            code_q <= code_d;
            v1_q   <= v1_d;
        end
    end

    // Stage 2 next state: update steers and pointer only for a valid sample;
    // with DWA off the pointer is parked at 0 so re-enabling starts there.
    always_comb begin
        sw_msb_d    = sw_msb_q;
        sw_msb_b_d  = sw_msb_b_q;
        sw_lsb_d    = sw_lsb_q;
        sw_lsb_b_d  = sw_lsb_b_q;
        dwa_ptr_d   = dwa_ptr_q;
        out_valid_d = v1_q;
        if (v1_q) begin
            sw_msb_d   = rot_cells;
            sw_msb_b_d = ~rot_cells;
            sw_lsb_d   = code_q[LSB_BITS-1:0];
            sw_lsb_b_d = ~code_q[LSB_BITS-1:0];
            dwa_ptr_d  = dem_en ? rot_next_ptr : '0;
        end
    end

    // Stage 2 register: reset steers all current to Iinb (zero code).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_msb_q    <= '0;
            sw_msb_b_q  <= '1;
            sw_lsb_q    <= '0;
            sw_lsb_b_q  <= '1;
            dwa_ptr_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sw_msb_q    <= sw_msb_d;
            sw_msb_b_q  <= sw_msb_b_d;
            sw_lsb_q    <= sw_lsb_d;
            sw_lsb_b_q  <= sw_lsb_b_d;
            dwa_ptr_q   <= dwa_ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sw_msb    = sw_msb_q;
    assign sw_msb_b  = sw_msb_b_q;
    assign sw_lsb    = sw_lsb_q;
    assign sw_lsb_b  = sw_lsb_b_q;
    assign dwa_ptr   = dwa_ptr_q;
    assign out_valid = out_valid_q;

endmodule : dac_switch_driver

// File: tb/tb_dac_switch_driver.sv
// Directed and randomised checks of the DAC switch driver: reset values,
// thermometer and DWA decoding, pointer wrap, valid gaps, mute and
// asynchronous reset, plus a randomised run against a small reference model.
module tb_dac_switch_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  din;
    logic        din_valid;
    logic        dem_en;
    logic        mute;
    logic [14:0] sw_msb;
    logic [14:0] sw_msb_b;
    logic [5:0]  sw_lsb;
    logic [5:0]  sw_lsb_b;
    logic [3:0]  dwa_ptr;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    dac_switch_driver dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .dem_en    (dem_en),
        .mute      (mute),
        .sw_msb    (sw_msb),
        .sw_msb_b  (sw_msb_b),
        .sw_lsb    (sw_lsb),
        .sw_lsb_b  (sw_lsb_b),
        .dwa_ptr   (dwa_ptr),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Full output check; complements are required to be exact inverses.
    task automatic chk_out(input string tag, input logic [14:0] msb, input logic [5:0] lsb,
                           input logic [3:0] ptr, input logic ov);
        logic [14:0] msb_b;
        logic [5:0]  lsb_b;
        msb_b = ~msb;
        lsb_b = ~lsb;
        chk({tag, "_sw_msb"},    32'(sw_msb),    32'(msb));
        chk({tag, "_sw_msb_b"},  32'(sw_msb_b),  32'(msb_b));
        chk({tag, "_sw_lsb"},    32'(sw_lsb),    32'(lsb));
        chk({tag, "_sw_lsb_b"},  32'(sw_lsb_b),  32'(lsb_b));
        chk({tag, "_dwa_ptr"},   32'(dwa_ptr),   32'(ptr));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
    endtask

    // Apply inputs for the next rising edge, then step just past it.
    task automatic drive(input logic v, input logic [9:0] d, input logic m, input logic de);
        din_valid = v;
        din       = d;
        mute      = m;
        dem_en    = de;
        @(posedge clk);
        #1;
    endtask

    // Randomised-run model state.
    logic        pend_v;
    logic [9:0]  pend_code;
    logic        cur_v;
    logic [9:0]  cur_d;
    logic        cur_m;
    logic        seg_dem;
    int          seg_left;
    int          exp_ptr;
    int          base;
    int          kk;
    logic [14:0] exp_msb;
    logic [5:0]  exp_lsb;
    logic        exp_ov;
    int          usage [15];
    int          u_max;
    int          u_min;

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        dem_en    = 1'b0;
        mute      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 15'h0000, 6'h00, 4'd0, 1'b0);
        rst = 1'b0;

        // Plain thermometer: k=10, lsb=0x25
        drive(1'b1, 10'h2A5, 1'b0, 1'b0);
        chk("therm_latency_ov", 32'(out_valid), 32'd0);
        drive(1'b0, 10'h000, 1'b0, 1'b0);
        chk_out("therm_k10", 15'h03FF, 6'h25, 4'd0, 1'b1);

        // DWA, k=6 three times back to back, wrapping at 15
        drive(1'b1, 10'h180, 1'b0, 1'b1);
        drive(1'b1, 10'h180, 1'b0, 1'b1);
        chk_out("dwa_k6_a", 15'h003F, 6'h00, 4'd6, 1'b1);
        drive(1'b1, 10'h180, 1'b0, 1'b1);
        chk_out("dwa_k6_b", 15'h0FC0, 6'h00, 4'd12, 1'b1);
        drive(1'b0, 10'h000, 1'b0, 1'b1);
        chk_out("dwa_k6_wrap", 15'h7007, 6'h00, 4'd3, 1'b1);

        // Move pointer to 5 (k=2), then full scale, then zero
        drive(1'b1, 10'h080, 1'b0, 1'b1);
        chk_out("idle_hold", 15'h7007, 6'h00, 4'd3, 1'b0);
        drive(1'b1, 10'h3FF, 1'b0, 1'b1);
        chk_out("dwa_k2", 15'h0018, 6'h00, 4'd5, 1'b1);
        drive(1'b1, 10'h000, 1'b0, 1'b1);
        chk_out("full_scale", 15'h7FFF, 6'h3F, 4'd5, 1'b1);
        drive(1'b0, 10'h000, 1'b0, 1'b1);
        chk_out("zero_code", 15'h0000, 6'h00, 4'd5, 1'b1);

        // Valid pattern 1,0,0,1 with mute on the last sample
        drive(1'b1, 10'h155, 1'b0, 1'b0);
        chk_out("gap_e1", 15'h0000, 6'h00, 4'd5, 1'b0);
        drive(1'b0, 10'h3FF, 1'b0, 1'b0);
        chk_out("gap_e2", 15'h001F, 6'h15, 4'd0, 1'b1);
        drive(1'b0, 10'h3FF, 1'b0, 1'b0);
        chk_out("gap_e3", 15'h001F, 6'h15, 4'd0, 1'b0);
        drive(1'b1, 10'h3FF, 1'b1, 1'b0);
        chk_out("gap_e4", 15'h001F, 6'h15, 4'd0, 1'b0);
        drive(1'b0, 10'h3FF, 1'b0, 1'b0);
        chk_out("mute_e5", 15'h0000, 6'h00, 4'd0, 1'b1);
        drive(1'b0, 10'h000, 1'b0, 1'b0);
        chk_out("gap_e6", 15'h0000, 6'h00, 4'd0, 1'b0);

        // Asynchronous reset between edges with a sample in flight
        drive(1'b1, 10'h180, 1'b0, 1'b1);
        drive(1'b1, 10'h2A5, 1'b0, 1'b1);
        chk_out("pre_rst", 15'h003F, 6'h00, 4'd6, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 15'h0000, 6'h00, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 10'h000, 1'b0, 1'b0);
        chk_out("post_rst", 15'h0000, 6'h00, 4'd0, 1'b0);

        // Randomised run with alternating DWA-off / DWA-on segments
        pend_v    = 1'b0;
        pend_code = '0;
        seg_dem   = 1'b1;
        seg_left  = 0;
        exp_ptr   = 0;
        exp_msb   = '0;
        exp_lsb   = '0;
        exp_ov    = 1'b0;
        for (int i = 0; i < 15; i++) usage[i] = 0;

        for (int c = 0; c < 3000; c++) begin
            if (seg_left == 0) begin
                seg_dem  = ~seg_dem;
                seg_left = int'($urandom_range(20, 200));
            end
            seg_left--;
            cur_v = ($urandom_range(0, 3) != 0);
            cur_d = 10'($urandom);
            cur_m = ($urandom_range(0, 7) == 0);
            drive(cur_v, cur_d, cur_m, seg_dem);

            exp_ov = pend_v;
            if (pend_v) begin
                kk      = int'(pend_code[9:6]);
                base    = seg_dem ? exp_ptr : 0;
                exp_msb = '0;
                for (int j = 0; j < kk; j++) exp_msb[(base + j) % 15] = 1'b1;
                exp_lsb = pend_code[5:0];
                exp_ptr = seg_dem ? ((exp_ptr + kk) % 15) : 0;
                chk("rand_popcount", 32'($countones(sw_msb)), 32'(kk));
                if (seg_dem) begin
                    for (int i = 0; i < 15; i++) usage[i] += int'(sw_msb[i]);
                    u_max = usage[0];
                    u_min = usage[0];
                    for (int i = 1; i < 15; i++) begin
                        if (usage[i] > u_max) u_max = usage[i];
                        if (usage[i] < u_min) u_min = usage[i];
                    end
                    chk("rand_dwa_balance", 32'((u_max - u_min) <= 1), 32'd1);
                end else begin
                    for (int i = 0; i < 15; i++) usage[i] = 0;
                end
            end
            chk_out("rand", exp_msb, exp_lsb, 4'(exp_ptr), exp_ov);

            pend_v = cur_v;
            if (cur_v) pend_code = cur_m ? 10'h000 : cur_d;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dac_switch_driver
